// File: rtl/sync_fifo_prog_pkg.sv
// ============================================================================
// Module  : sync_fifo_prog_pkg
// Brief   : Shared defaults, read-mode encodings and helpers for sync_fifo_prog.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_fifo_prog_pkg;

    localparam int c_DEF_WIDTH      = 16;
    localparam int c_DEF_DEPTH      = 16;
    localparam int c_FIFO_MODE_STD  = 0;
    localparam int c_FIFO_MODE_FWFT = 1;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Pointer width shared with the dual-clock FIFO; never narrower than one bit.
    function automatic int fifo_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit fifo_is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_prog_ram.sv
// ============================================================================
// Module  : fifo_ram
// Brief   : DEPTH x WIDTH storage, synchronous write port, asynchronous read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ram #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_wr_en,
    input  logic [PTR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]     i_wdata,
    input  logic [PTR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]     o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_prog.sv
// ============================================================================
// Module  : sync_fifo_prog
// Brief   : Single-clock FIFO with standard/FWFT read, programmable thresholds,
//           occupancy count, synchronous flush and rejected-access pulses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_prog
    import sync_fifo_prog_pkg::*;
#(
    parameter int WIDTH     = c_DEF_WIDTH,
    parameter int DEPTH     = c_DEF_DEPTH,
    parameter int FWFT      = c_FIFO_MODE_STD,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int PTR_WIDTH = fifo_ptr_width(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 wr_en_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 rd_en_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic                 rvalid_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 almost_full_o,
    output logic                 almost_empty_o,
    output logic [PTR_WIDTH:0]   count_o,
    output logic                 wr_error_o,
    output logic                 rd_error_o
);

    localparam logic [PTR_WIDTH:0]   c_CNT_FULL = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   c_CNT_AF   = (PTR_WIDTH + 1)'(AF_THRESH);
    localparam logic [PTR_WIDTH:0]   c_CNT_AE   = (PTR_WIDTH + 1)'(AE_THRESH);
    localparam logic [PTR_WIDTH:0]   c_CNT_ONE  = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH-1:0] c_PTR_ONE  = PTR_WIDTH'(1);

    if (!fifo_is_pow2(DEPTH) || (DEPTH < 2)) begin : g_chk_depth
        $error("sync_fifo_prog: DEPTH=%0d must be a power of two >= 2", DEPTH);
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_chk_af
        $error("sync_fifo_prog: AF_THRESH=%0d out of range 1..%0d", AF_THRESH, DEPTH);
    end
    if ((AE_THRESH < 0) || (AE_THRESH >= AF_THRESH)) begin : g_chk_ae
        $error("sync_fifo_prog: AE_THRESH=%0d must be in 0..AF_THRESH-1", AE_THRESH);
    end
    if ((FWFT != c_FIFO_MODE_STD) && (FWFT != c_FIFO_MODE_FWFT)) begin : g_chk_mode
        $error("sync_fifo_prog: FWFT=%0d must be 0 or 1", FWFT);
    end

    logic [PTR_WIDTH-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [PTR_WIDTH-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [PTR_WIDTH:0]   r_count_q,  w_count_d;
    logic                 r_wr_err_q, w_wr_err_d;
    logic                 r_rd_err_q, w_rd_err_d;
    fifo_flags_t          w_flags;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic                 w_ram_we;
    logic [WIDTH-1:0]     w_ram_rdata;

    always_comb begin
        w_flags.full         = (r_count_q == c_CNT_FULL);
        w_flags.empty        = (r_count_q == '0);
        w_flags.almost_full  = (r_count_q >= c_CNT_AF);
        w_flags.almost_empty = (r_count_q <= c_CNT_AE);
    end

    // Acceptance depends only on the registered flags, so a full FIFO rejects a
    // write even when a read frees a slot in the same cycle (and vice versa).
    assign w_wr_acc = wr_en_i && !w_flags.full;
    assign w_rd_acc = rd_en_i && !w_flags.empty;
    assign w_ram_we = w_wr_acc && !flush_i && !rst_i;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        w_wr_err_d = 1'b0;
        w_rd_err_d = 1'b0;
        if (flush_i) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (w_wr_acc) begin
                w_wr_ptr_d = r_wr_ptr_q + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                w_rd_ptr_d = r_rd_ptr_q + c_PTR_ONE;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   w_count_d = r_count_q + c_CNT_ONE;
                2'b01:   w_count_d = r_count_q - c_CNT_ONE;
                default: w_count_d = r_count_q;
            endcase
            w_wr_err_d = wr_en_i && w_flags.full;
            w_rd_err_d = rd_en_i && w_flags.empty;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
            r_wr_err_q <= 1'b0;
            r_rd_err_q <= 1'b0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
            r_wr_err_q <= w_wr_err_d;
            r_rd_err_q <= w_rd_err_d;
        end
    end

    fifo_ram #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_ram (
        .i_clk   (clk_i),
        .i_wr_en (w_ram_we),
        .i_waddr (r_wr_ptr_q),
        .i_wdata (wdata_i),
        .i_raddr (r_rd_ptr_q),
        .o_rdata (w_ram_rdata)
    );

    if (FWFT == c_FIFO_MODE_FWFT) begin : g_fwft
        assign rdata_o  = w_ram_rdata;
        assign rvalid_o = !w_flags.empty;
    end else begin : g_std
        logic [WIDTH-1:0] r_rdata_q, w_rdata_d;
        logic             r_rvalid_q, w_rvalid_d;

        always_comb begin
            w_rdata_d  = r_rdata_q;
            w_rvalid_d = 1'b0;
            if (!flush_i && w_rd_acc) begin
                w_rdata_d  = w_ram_rdata;
                w_rvalid_d = 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_rdata_q  <= '0;
                r_rvalid_q <= 1'b0;
            end else begin
                r_rdata_q  <= w_rdata_d;
                r_rvalid_q <= w_rvalid_d;
            end
        end

        assign rdata_o  = r_rdata_q;
        assign rvalid_o = r_rvalid_q;
    end

    assign full_o         = w_flags.full;
    assign empty_o        = w_flags.empty;
    assign almost_full_o  = w_flags.almost_full;
    assign almost_empty_o = w_flags.almost_empty;
    assign count_o        = r_count_q;
    assign wr_error_o     = r_wr_err_q;
    assign rd_error_o     = r_rd_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
// ============================================================================
// Module  : tb_sync_fifo_prog
// Brief   : Directed and random checks of standard and FWFT sync_fifo_prog
//           instances against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_prog;

    localparam int c_W  = 16;
    localparam int c_D  = 16;
    localparam int c_AF = 14;
    localparam int c_AE = 2;

    logic            clk   = 1'b0;
    logic            rst   = 1'b0;
    logic            flush = 1'b0;
    logic            wr_en = 1'b0;
    logic            rd_en = 1'b0;
    logic [c_W-1:0]  wdata = '0;

    logic [c_W-1:0]  a_rdata, b_rdata;
    logic            a_rvalid, b_rvalid, a_full, b_full, a_empty, b_empty;
    logic            a_af, b_af, a_ae, b_ae, a_werr, b_werr, a_rerr, b_rerr;
    logic [4:0]      a_count, b_count;

    sync_fifo_prog #(.WIDTH(c_W), .DEPTH(c_D), .FWFT(0)) u_std (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_en_i(wr_en), .wdata_i(wdata),
        .rd_en_i(rd_en), .rdata_o(a_rdata), .rvalid_o(a_rvalid), .full_o(a_full),
        .empty_o(a_empty), .almost_full_o(a_af), .almost_empty_o(a_ae),
        .count_o(a_count), .wr_error_o(a_werr), .rd_error_o(a_rerr)
    );

    sync_fifo_prog #(.WIDTH(c_W), .DEPTH(c_D), .FWFT(1)) u_fwft (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_en_i(wr_en), .wdata_i(wdata),
        .rd_en_i(rd_en), .rdata_o(b_rdata), .rvalid_o(b_rvalid), .full_o(b_full),
        .empty_o(b_empty), .almost_full_o(b_af), .almost_empty_o(b_ae),
        .count_o(b_count), .wr_error_o(b_werr), .rd_error_o(b_rerr)
    );

    always #5 clk = ~clk;

    int             n_pass  = 0;
    int             n_total = 0;
    logic [c_W-1:0] mq[$];
    logic [c_W-1:0] m_rdata  = '0;
    logic           m_rvalid = 1'b0;
    logic           m_werr   = 1'b0;
    logic           m_rerr   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("std.count",  32'(a_count), n);
        chk("std.empty",  32'(a_empty), 32'(n == 0));
        chk("std.full",   32'(a_full),  32'(n == c_D));
        chk("std.afull",  32'(a_af),    32'(n >= c_AF));
        chk("std.aempty", 32'(a_ae),    32'(n <= c_AE));
        chk("std.rvalid", 32'(a_rvalid), 32'(m_rvalid));
        chk("std.rdata",  32'(a_rdata), 32'(m_rdata));
        chk("std.wr_err", 32'(a_werr),  32'(m_werr));
        chk("std.rd_err", 32'(a_rerr),  32'(m_rerr));
        chk("fwft.count", 32'(b_count), n);
        chk("fwft.flags", {28'd0, b_full, b_empty, b_af, b_ae},
            {28'd0, n == c_D, n == 0, n >= c_AF, n <= c_AE});
        chk("fwft.errs",  {30'd0, b_werr, b_rerr}, {30'd0, m_werr, m_rerr});
        chk("fwft.rvalid", 32'(b_rvalid), 32'(n != 0));
        if (n != 0) begin
            chk("fwft.rdata", 32'(b_rdata), 32'(mq[0]));
        end
    endtask

    // One clock: apply inputs, advance the model by the same rules, compare.
    task automatic cycle(input bit w, input logic [c_W-1:0] d, input bit r,
                         input bit f, input bit rs);
        int n;
        wr_en = w; wdata = d; rd_en = r; flush = f; rst = rs;
        @(posedge clk);
        #1;
        n = mq.size();
        if (rs) begin
            mq.delete();
            m_rdata = '0; m_rvalid = 1'b0; m_werr = 1'b0; m_rerr = 1'b0;
        end else if (f) begin
            mq.delete();
            m_rvalid = 1'b0; m_werr = 1'b0; m_rerr = 1'b0;
        end else begin
            m_werr   = w && (n == c_D);
            m_rerr   = r && (n == 0);
            m_rvalid = 1'b0;
            if (r && (n != 0)) begin
                m_rdata  = mq.pop_front();
                m_rvalid = 1'b1;
            end
            if (w && (n != c_D)) begin
                mq.push_back(d);
            end
        end
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; rst = 1'b0;
        check_all();
    endtask

    initial begin
        cycle(0, '0, 0, 0, 1);
        cycle(0, '0, 0, 0, 1);

        // Reset while holding five words.
        for (int i = 0; i < 5; i++) cycle(1, 16'(16'h0A00 + i), 0, 0, 0);
        chk("pre_reset.count", 32'(a_count), 32'd5);
        cycle(0, '0, 1, 0, 1);
        cycle(1, 16'h00FF, 0, 0, 1);
        chk("reset.rdata", 32'(a_rdata), 32'h0);

        // Fill past full, then drain past empty.
        for (int i = 1; i <= 17; i++) cycle(1, 16'(i), 0, 0, 0);
        chk("fill.count", 32'(a_count), 32'd16);
        for (int i = 1; i <= 17; i++) cycle(0, '0, 1, 0, 0);
        chk("drain.hold", 32'(a_rdata), 32'h0010);

        // Wrap, then simultaneous access at steady occupancy.
        for (int i = 0; i < 10; i++) cycle(1, 16'(16'h0100 + i), 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, '0, 1, 0, 0);
        for (int i = 0; i < 12; i++) cycle(1, 16'(16'h0200 + i), 0, 0, 0);
        for (int i = 0; i < 8; i++)  cycle(1, 16'(16'h0300 + i), 1, 0, 0);
        chk("simul.count", 32'(a_count), 32'd12);
        for (int i = 0; i < 12; i++) cycle(0, '0, 1, 0, 0);
        cycle(1, 16'h0055, 1, 0, 0);
        chk("empty_simul.count", 32'(a_count), 32'd1);
        cycle(0, '0, 1, 0, 0);

        // Flush with a concurrent write request.
        for (int i = 0; i < 7; i++) cycle(1, 16'(16'h0400 + i), 0, 0, 0);
        cycle(1, 16'hDEAD, 0, 1, 0);
        cycle(1, 16'h1234, 0, 0, 0);
        cycle(0, '0, 1, 0, 0);
        chk("flush.readback", 32'(a_rdata), 32'h1234);

        // FWFT display of a single word.
        cycle(1, 16'hABCD, 0, 0, 0);
        chk("fwft.show", {15'd0, b_rvalid, b_rdata}, {15'd0, 1'b1, 16'hABCD});
        cycle(0, '0, 1, 0, 0);
        chk("fwft.popped", {30'd0, b_rvalid, b_empty}, {30'd0, 1'b0, 1'b1});

        // Random traffic with alternating write/read bias, rare flush and reset.
        for (int ph = 0; ph < 8; ph++) begin
            int pw;
            int pr;
            pw = (ph % 2 == 0) ? 75 : 30;
            pr = (ph % 2 == 0) ? 35 : 70;
            for (int i = 0; i < 80; i++) begin
                cycle($urandom_range(99) < pw, 16'($urandom), $urandom_range(99) < pr,
                      $urandom_range(59) == 0, $urandom_range(199) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
